// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: default depth/threshold,
// exception-code width and the layout of one queue entry.
package inst_queue_pkg;

  localparam int IQ_DEPTH_DEF  = 16;
  localparam int IQ_THRESH_DEF = 8;
  localparam int EXCCODE_W     = 5;

  localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'h04;

  typedef struct packed {
    logic [31:0]          inst;
    logic [31:0]          pc;
    logic                 has_exc;
    logic [EXCCODE_W-1:0] exc_code;
  } iq_entry_t;

endpackage

// File: rtl/iq_compact.sv
// Packs the enabled words of a fetch bundle to the low positions, keeping
// each word's original index so its PC can be rebuilt.
module iq_compact (
  input  logic [127:0] words,
  input  logic [3:0]   mask,
  output logic [127:0] packed_words,
  output logic [7:0]   packed_idx,
  output logic [2:0]   num
);

  logic [2:0] pos;

  always_comb begin
    packed_words = '0;
    packed_idx   = '0;
    pos          = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        packed_words[pos[1:0]*32 +: 32] = words[i*32 +: 32];
        packed_idx[pos[1:0]*2 +: 2]     = 2'(i);
        pos                             = pos + 3'd1;
      end
    end
    num = pos;
  end

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode: accepts up to four
// compacted words per cycle and presents the two oldest entries to decode.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int IQ_DEPTH  = IQ_DEPTH_DEF,
  parameter int IQ_THRESH = IQ_THRESH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   IF_valid_i,
  input  logic [127:0]           IF_inst_i,
  input  logic [31:0]            IF_VAddr_i,
  input  logic [3:0]             IF_instEnable_i,
  input  logic                   IF_hasException_i,
  input  logic [EXCCODE_W-1:0]   IF_ExcCode_i,
  input  logic [1:0]             ID_takeNum_i,
  output logic [1:0]             IQ_valid_o,
  output logic [63:0]            IQ_inst_o,
  output logic [63:0]            IQ_PC_o,
  output logic [1:0]             IQ_hasException_o,
  output logic [2*EXCCODE_W-1:0] IQ_ExcCode_o,
  output logic                   IQ_stopFetch_o
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   sum_t;

  iq_entry_t mem [IQ_DEPTH];
  ptr_t      head;
  ptr_t      tail;
  cnt_t      count;

  logic [127:0] cmp_words;
  logic [7:0]   cmp_idx;
  logic [2:0]   cmp_num;

  logic [2:0]   n_in;
  logic [2:0]   n_wr;
  logic         wr_en;
  logic [1:0]   take;
  iq_entry_t    wr_entry [4];

  iq_compact u_compact (
    .words        (IF_inst_i),
    .mask         (IF_instEnable_i),
    .packed_words (cmp_words),
    .packed_idx   (cmp_idx),
    .num          (cmp_num)
  );

  // A bundle that would overflow is dropped whole; fetch throttling keeps this from happening.
  always_comb begin
    n_in  = IF_hasException_i ? 3'd1 : cmp_num;
    wr_en = IF_valid_i && !flush_i &&
            ((sum_t'(count) + sum_t'(n_in)) <= sum_t'(IQ_DEPTH));
    n_wr  = wr_en ? n_in : 3'd0;
    take  = (cnt_t'(ID_takeNum_i) > count) ? count[1:0] : ID_takeNum_i;
    for (int j = 0; j < 4; j++) begin
      wr_entry[j].inst     = IF_hasException_i ? 32'h0 : cmp_words[j*32 +: 32];
      wr_entry[j].pc       = IF_hasException_i ? IF_VAddr_i
                                               : {IF_VAddr_i[31:4], cmp_idx[j*2 +: 2], 2'b00};
      wr_entry[j].has_exc  = IF_hasException_i;
      wr_entry[j].exc_code = IF_hasException_i ? IF_ExcCode_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < n_in) begin
          mem[tail + ptr_t'(j)] <= wr_entry[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(take);
      tail  <= tail + ptr_t'(n_wr);
      count <= count - cnt_t'(take) + cnt_t'(n_wr);
    end
  end

  // Empty slots read as zero, which also covers the reset state since count is cleared.
  always_comb begin
    IQ_valid_o        = '0;
    IQ_inst_o         = '0;
    IQ_PC_o           = '0;
    IQ_hasException_o = '0;
    IQ_ExcCode_o      = '0;
    for (int k = 0; k < 2; k++) begin
      if (count > cnt_t'(k)) begin
        IQ_valid_o[k]                             = 1'b1;
        IQ_inst_o[k*32 +: 32]                     = mem[head + ptr_t'(k)].inst;
        IQ_PC_o[k*32 +: 32]                       = mem[head + ptr_t'(k)].pc;
        IQ_hasException_o[k]                      = mem[head + ptr_t'(k)].has_exc;
        IQ_ExcCode_o[k*EXCCODE_W +: EXCCODE_W]    = mem[head + ptr_t'(k)].exc_code;
      end
    end
  end

  assign IQ_stopFetch_o = count > cnt_t'(IQ_THRESH);

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver pushes expected entries as it
// issues bundles, a negedge monitor pops and compares what decode consumes.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush_i = 1'b0;
  logic         IF_valid_i = 1'b0;
  logic [127:0] IF_inst_i = '0;
  logic [31:0]  IF_VAddr_i = '0;
  logic [3:0]   IF_instEnable_i = '0;
  logic         IF_hasException_i = 1'b0;
  logic [4:0]   IF_ExcCode_i = '0;
  logic [1:0]   ID_takeNum_i = '0;
  logic [1:0]   IQ_valid_o;
  logic [63:0]  IQ_inst_o;
  logic [63:0]  IQ_PC_o;
  logic [1:0]   IQ_hasException_o;
  logic [9:0]   IQ_ExcCode_o;
  logic         IQ_stopFetch_o;

  iq_entry_t sbq[$];
  int        expCount = 0;
  int        nChecks = 0;
  int        nFail = 0;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .IF_valid_i        (IF_valid_i),
    .IF_inst_i         (IF_inst_i),
    .IF_VAddr_i        (IF_VAddr_i),
    .IF_instEnable_i   (IF_instEnable_i),
    .IF_hasException_i (IF_hasException_i),
    .IF_ExcCode_i      (IF_ExcCode_i),
    .ID_takeNum_i      (ID_takeNum_i),
    .IQ_valid_o        (IQ_valid_o),
    .IQ_inst_o         (IQ_inst_o),
    .IQ_PC_o           (IQ_PC_o),
    .IQ_hasException_o (IQ_hasException_o),
    .IQ_ExcCode_o      (IQ_ExcCode_o),
    .IQ_stopFetch_o    (IQ_stopFetch_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkSlot(input string name, input int k, input iq_entry_t e);
    check({name, " inst"}, IQ_inst_o[k*32 +: 32], e.inst);
    check({name, " pc"},   IQ_PC_o[k*32 +: 32],   e.pc);
    check({name, " exc"},  {31'b0, IQ_hasException_o[k]}, {31'b0, e.has_exc});
    check({name, " code"}, {27'b0, IQ_ExcCode_o[k*5 +: 5]}, {27'b0, e.exc_code});
  endtask

  // Per-cycle view: valid bits, throttle and visible slots against the scoreboard.
  task automatic checkOutput(input string name);
    logic [1:0] ev;
    iq_entry_t  z;
    z = '0;
    ev[0] = expCount > 0;
    ev[1] = expCount > 1;
    check({name, " valid"}, {30'b0, IQ_valid_o}, {30'b0, ev});
    check({name, " stop"}, {31'b0, IQ_stopFetch_o}, {31'b0, (expCount > 8)});
    for (int k = 0; k < 2; k++) begin
      if (ev[k]) checkSlot($sformatf("%s slot%0d", name, k), k, sbq[k]);
      else       checkSlot($sformatf("%s idle%0d", name, k), k, z);
    end
  endtask

  task automatic applyStimulus(input string name, input logic valid, input logic [31:0] vaddr,
                               input logic [3:0] mask, input logic exc, input logic [4:0] code,
                               input logic [1:0] takeNum, input logic flush, input logic [23:0] tag);
    int           n;
    int           take;
    logic [127:0] words;
    n = 0;
    for (int i = 0; i < 4; i++) words[i*32 +: 32] = {tag, 6'h0, 2'(i)};
    take = (takeNum > expCount) ? expCount : int'(takeNum);
    if (valid && !flush) begin
      n = exc ? 1 : $countones(mask);
      if (expCount + n <= 16) begin
        if (exc) sbq.push_back('{32'h0, vaddr, 1'b1, code});
        else begin
          for (int i = 0; i < 4; i++)
            if (mask[i]) sbq.push_back('{words[i*32 +: 32], {vaddr[31:4], 2'(i), 2'b00}, 1'b0, 5'h0});
        end
      end else n = 0;
    end
    IF_valid_i        = valid;
    IF_VAddr_i        = vaddr;
    IF_instEnable_i   = mask;
    IF_hasException_i = exc;
    IF_ExcCode_i      = code;
    IF_inst_i         = words;
    ID_takeNum_i      = takeNum;
    flush_i           = flush;
    @(posedge clk);
    #1;
    if (flush) begin
      sbq.delete();
      expCount = 0;
    end else expCount = expCount - take + n;
    IF_valid_i   = 1'b0;
    ID_takeNum_i = 2'd0;
    flush_i      = 1'b0;
    checkOutput(name);
  endtask

  // Monitor: whatever decode consumes this cycle must match the oldest expected entries.
  always @(negedge clk) begin
    int take;
    if (rst && !flush_i) begin
      take = (ID_takeNum_i > expCount) ? expCount : int'(ID_takeNum_i);
      for (int k = 0; k < take; k++) begin
        check($sformatf("mon valid%0d", k), {31'b0, IQ_valid_o[k]}, 32'h1);
        if (sbq.size() > k) checkSlot($sformatf("mon slot%0d", k), k, sbq[k]);
      end
      for (int k = 0; k < take; k++) if (sbq.size() > 0) void'(sbq.pop_front());
    end
  end

  initial begin
    logic [3:0] wrapMask [4];
    wrapMask[0] = 4'b1111;
    wrapMask[1] = 4'b0000;
    wrapMask[2] = 4'b0110;
    wrapMask[3] = 4'b1001;

    IF_valid_i = 1'b1;
    IF_instEnable_i = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    IF_valid_i = 1'b0;
    rst = 1'b1;

    applyStimulus("first", 1, 32'hBFC00000, 4'b1111, 0, 0, 0, 0, 24'h000001);
    check("first pc0", IQ_PC_o[31:0], 32'hBFC00000);
    check("first pc1", IQ_PC_o[63:32], 32'hBFC00004);
    check("first valid", {30'b0, IQ_valid_o}, 32'h3);
    applyStimulus("drain0", 0, 0, 0, 0, 0, 2, 0, 0);
    check("drain0 pc0", IQ_PC_o[31:0], 32'hBFC00008);
    applyStimulus("drain1", 0, 0, 0, 0, 0, 2, 0, 0);
    check("drain1 valid", {30'b0, IQ_valid_o}, 32'h0);

    applyStimulus("upper", 1, 32'h80000008, 4'b1100, 0, 0, 0, 0, 24'h000002);
    check("upper pc0", IQ_PC_o[31:0], 32'h80000008);
    check("upper pc1", IQ_PC_o[63:32], 32'h8000000C);
    applyStimulus("word0", 1, 32'h80000000, 4'b0001, 0, 0, 0, 0, 24'h000003);
    applyStimulus("take2", 0, 0, 0, 0, 0, 2, 0, 0);
    check("take2 pc0", IQ_PC_o[31:0], 32'h80000000);
    check("take2 valid", {30'b0, IQ_valid_o}, 32'h1);
    applyStimulus("clamp", 0, 0, 0, 0, 0, 2, 0, 0);
    check("clamp valid", {30'b0, IQ_valid_o}, 32'h0);

    applyStimulus("exc", 1, 32'h80000002, 4'b1111, 1, EXC_ADEL, 0, 0, 24'h000004);
    check("exc pc0", IQ_PC_o[31:0], 32'h80000002);
    check("exc inst0", IQ_inst_o[31:0], 32'h0);
    check("exc flag", {30'b0, IQ_hasException_o}, 32'h1);
    check("exc code", {27'b0, IQ_ExcCode_o[4:0]}, 32'h4);
    check("exc valid", {30'b0, IQ_valid_o}, 32'h1);
    applyStimulus("exc take", 0, 0, 0, 0, 0, 1, 0, 0);

    applyStimulus("fill4", 1, 32'h80000100, 4'b1111, 0, 0, 0, 0, 24'h000005);
    applyStimulus("fill8", 1, 32'h80000110, 4'b1111, 0, 0, 0, 0, 24'h000006);
    check("fill8 stop", {31'b0, IQ_stopFetch_o}, 32'h0);
    applyStimulus("fill9", 1, 32'h80000120, 4'b0010, 0, 0, 0, 0, 24'h000007);
    check("fill9 stop", {31'b0, IQ_stopFetch_o}, 32'h1);
    applyStimulus("to7", 0, 0, 0, 0, 0, 2, 0, 0);
    check("to7 stop", {31'b0, IQ_stopFetch_o}, 32'h0);
    repeat (4) applyStimulus("drain", 0, 0, 0, 0, 0, 2, 0, 0);

    applyStimulus("rw pre", 1, 32'h80000200, 4'b1111, 0, 0, 0, 0, 24'h000008);
    applyStimulus("rw", 1, 32'h80000210, 4'b1111, 0, 0, 2, 0, 24'h000009);
    applyStimulus("flush", 1, 32'h80000220, 4'b1111, 0, 0, 2, 1, 24'h00000A);
    check("flush valid", {30'b0, IQ_valid_o}, 32'h0);

    for (int c = 0; c < 24; c++)
      applyStimulus("wrap", 1, 32'h80001000 + 32'(c * 16), wrapMask[c % 4], 0, 0, 2, 0, 24'(c + 16));
    repeat (3) applyStimulus("wrap drain", 0, 0, 0, 0, 0, 2, 0, 0);

    applyStimulus("mid a", 1, 32'h80002000, 4'b1111, 0, 0, 0, 0, 24'h000030);
    applyStimulus("mid b", 1, 32'h80002010, 4'b0001, 0, 0, 0, 0, 24'h000031);
    #2;
    rst = 1'b0;
    #1;
    check("async valid", {30'b0, IQ_valid_o}, 32'h0);
    check("async pc0", IQ_PC_o[31:0], 32'h0);
    sbq.delete();
    expCount = 0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("after rst", 1, 32'hBFC00040, 4'b1111, 0, 0, 0, 0, 24'h000040);
    check("after rst pc0", IQ_PC_o[31:0], 32'hBFC00040);
    check("after rst valid", {30'b0, IQ_valid_o}, 32'h3);
    repeat (2) applyStimulus("final", 0, 0, 0, 0, 0, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 16, queue entries (power of two, at least 12).
REQ-002 Parameter IQ_THRESH, default 8, occupancy above which fetch is stopped.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 flush_i  in  1  pipeline flush: CP0 exception, or front or back branch-prediction recovery.
REQ-006 IF_valid_i  in  1  fetch bundle present this cycle.
REQ-007 IF_inst_i  in  128  four words; word i is at bits [32i+31:32i].
REQ-008 IF_VAddr_i  in  32  bundle VAddr; bits [31:4] are the line base, bits [1:0] are the misalignment bits.
REQ-009 IF_instEnable_i  in  4  bit i set means word i is wanted.
REQ-010 IF_hasException_i  in  1  fetch address exception.
REQ-011 IF_ExcCode_i  in  5  exception code.
REQ-012 ID_takeNum_i  in  2  entries consumed by decode this cycle (0..2).
REQ-013 IQ_valid_o  out  2  bit k set means output slot k holds a valid entry.
REQ-014 IQ_inst_o  out  64  slot k instruction at bits [32k+31:32k].
REQ-015 IQ_PC_o  out  64  slot k PC, same packing as IQ_inst_o.
REQ-016 IQ_hasException_o  out  2  per-slot exception flag.
REQ-017 IQ_ExcCode_o  out  10  per-slot exception code, 5 bits per slot.
REQ-018 IQ_stopFetch_o  out  1  tells fetch to drop inst_req.

Function
REQ-019 The queue SHALL be a circular buffer with head pointer, tail pointer and count; each entry holds {inst, PC, hasException, ExcCode}.
REQ-020 Normal write (IF_valid_i=1, flush_i=0, IF_hasException_i=0):
  - n = popcount(IF_instEnable_i) entries SHALL be appended at the tail in ascending word order.
  - Each entry SHALL have PC = {IF_VAddr_i[31:4], i[1:0], 2'b00} and hasException=0.
  - The entries are compacted, so no holes are written.
REQ-021 Exception write (IF_valid_i=1, flush_i=0, IF_hasException_i=1):
  - Exactly one entry SHALL be appended: inst=32'h0, PC=IF_VAddr_i unmodified, hasException=1, ExcCode=IF_ExcCode_i.
  - IF_instEnable_i is ignored.
REQ-022 If count+n exceeds IQ_DEPTH, the entire bundle SHALL be discarded and count left unchanged; this is a protocol error guarded by REQ-027.
REQ-023 Output slot k SHALL combinationally present entry head+k; IQ_valid_o[k] = (count > k).
REQ-024 Read: take = min(ID_takeNum_i, count); head advances by take modulo IQ_DEPTH.
REQ-025 Simultaneous read and write in one cycle:
  - Count SHALL update to count - take + n.
  - Written entries become visible at the outputs the next cycle (no bypass).
REQ-026 flush_i=1 SHALL force head=tail=count=0 next cycle; it overrides the write and read in that cycle.
REQ-027 IQ_stopFetch_o SHALL equal (count > IQ_THRESH) and be decoded from registered count only. This leaves room for one accepted bundle plus one returning bundle.
REQ-028 Pointers SHALL wrap modulo IQ_DEPTH; count SHALL range 0..IQ_DEPTH.
REQ-029 Non-valid output slots SHALL drive inst, PC, flags and codes as zero.

Reset
REQ-030 While rst=0, asynchronously: head=tail=count=0, IQ_valid_o=2'b00, IQ_stopFetch_o=0, and all data outputs zero.
REQ-031 Entry storage need not be reset; outputs are masked by REQ-029.
REQ-032 Reset deasserted mid-stream SHALL start from an empty queue; the first write is accepted in the first clk edge after release.

Structure
REQ-033 The shared defines header SHALL hold IQ_DEPTH, IQ_THRESH, the EXCCODE width, and the entry field layout.
REQ-034 The compaction of enabled words SHALL be the sub-module iq_compact:
  - Inputs: 4 words and 4-bit mask.
  - Outputs: 4 packed words, 4 packed word indices, and a 3-bit count.
  - Purely combinational.

Verification
REQ-035 Reset, then write VAddr=0xBFC00000, mask=1111 -> next cycle count=4, slot0 PC=0xBFC00000, slot1 PC=0xBFC00004, valid=11.
REQ-036 Write VAddr=0x80000008, mask=1100 -> two entries with PC 0x80000008 and 0x8000000C; mask=0001 -> one entry with PC 0x80000000.
REQ-037 Write with hasException=1, VAddr=0x80000002, ExcCode=ADEL -> one entry, PC=0x80000002, inst=0, IQ_hasException_o[0]=1.
REQ-038 Fill to count=9 with takeNum=0 -> IQ_stopFetch_o=1; take 2 -> count=7, stopFetch=0. Full drain takeNum=2 with count=1 -> take clamps to 1, count=0.
REQ-039 Write 4 with take 2 and flush_i=1 in the same cycle -> count=0, valid=00. Also run wrap-around over 3*IQ_DEPTH entries -> PCs stay in order, no loss.
